// File: rtl/rv_mem_pkg.sv
// Load/store codes shared with the control unit, plus the controller state
// encoding and small access-shape helpers.
package rv_mem_pkg;

    localparam logic [2:0] LOAD_NONE  = 3'b000;
    localparam logic [2:0] LOAD_LB    = 3'b001;
    localparam logic [2:0] LOAD_LH    = 3'b010;
    localparam logic [2:0] LOAD_LW    = 3'b011;
    localparam logic [2:0] LOAD_LBU   = 3'b100;
    localparam logic [2:0] LOAD_LHU   = 3'b101;

    localparam logic [2:0] STORE_NONE = 3'b000;
    localparam logic [2:0] STORE_SB   = 3'b001;
    localparam logic [2:0] STORE_SH   = 3'b010;
    localparam logic [2:0] STORE_SW   = 3'b011;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } access_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } mem_state_e;

    function automatic logic load_code_valid(input logic [2:0] code);
        case (code)
            LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    function automatic logic store_code_valid(input logic [2:0] code);
        case (code)
            STORE_SB, STORE_SH, STORE_SW: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic access_size_e load_size(input logic [2:0] code);
        case (code)
            LOAD_LB, LOAD_LBU: return SIZE_BYTE;
            LOAD_LH, LOAD_LHU: return SIZE_HALF;
            default:           return SIZE_WORD;
        endcase
    endfunction

    function automatic access_size_e store_size(input logic [2:0] code);
        case (code)
            STORE_SB: return SIZE_BYTE;
            STORE_SH: return SIZE_HALF;
            default:  return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input access_size_e size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~offset[0];
            default:   return (offset == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input access_size_e size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 4'b0001 << offset;
            SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    // Narrow stores are copied onto every lane so the byte enables alone pick the target.
    function automatic logic [31:0] replicate(input access_size_e size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends
// it according to the load code.
module load_extend
    import rv_mem_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  byte_offset,
    input  logic [2:0]  load_code,
    output logic [31:0] result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (byte_offset)
            2'd0:    lane_byte = mem_word[7:0];
            2'd1:    lane_byte = mem_word[15:8];
            2'd2:    lane_byte = mem_word[23:16];
            default: lane_byte = mem_word[31:24];
        endcase

        lane_half = byte_offset[1] ? mem_word[31:16] : mem_word[15:0];

        case (load_code)
            LOAD_LB:  result = {{24{lane_byte[7]}}, lane_byte};
            LOAD_LBU: result = {24'd0, lane_byte};
            LOAD_LH:  result = {{16{lane_half[15]}}, lane_half};
            LOAD_LHU: result = {16'd0, lane_half};
            LOAD_LW:  result = mem_word;
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: turns decoded load/store requests into word-addressed
// memory strobes with lane enables, wait handling, timeout and error reporting.
module data_mem_ctrl
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  MEM_READ,
    input  logic [2:0]  MEM_WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY,
    output logic        ERROR,
    output logic        MAIN_READ,
    output logic        MAIN_WRITE,
    output logic [29:0] MAIN_ADDRESS,
    output logic [31:0] MAIN_WRITEDATA,
    output logic [3:0]  MAIN_BYTE_EN,
    input  logic [31:0] MAIN_READDATA,
    input  logic        MAIN_BUSYWAIT
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_next;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      read_data_q;
    logic [31:0]      load_result;
    logic [3:0]       byte_en_q;
    logic [2:0]       load_code_q;
    logic             main_read_q;
    logic             main_write_q;
    logic             error_q;
    logic             req_rd;
    logic             req_wr;
    logic             any_req;
    logic             legal_req;
    access_size_e     req_size;

    assign req_rd  = (MEM_READ != LOAD_NONE);
    assign req_wr  = (MEM_WRITE != STORE_NONE);
    assign any_req = req_rd | req_wr;

    // A request is legal only if it is exactly one known load or store at a natural alignment.
    always_comb begin
        req_size  = req_rd ? load_size(MEM_READ) : store_size(MEM_WRITE);
        legal_req = 1'b0;
        if (req_rd && !req_wr) begin
            legal_req = load_code_valid(MEM_READ) && is_aligned(req_size, ADDRESS[1:0]);
        end else if (req_wr && !req_rd) begin
            legal_req = store_code_valid(MEM_WRITE) && is_aligned(req_size, ADDRESS[1:0]);
        end
    end

    assign wait_next = wait_cnt + 1'b1;

    load_extend u_load_extend (
        .mem_word    (MAIN_READDATA),
        .byte_offset (addr_q[1:0]),
        .load_code   (load_code_q),
        .result      (load_result)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            byte_en_q    <= 4'd0;
            load_code_q  <= LOAD_NONE;
            read_data_q  <= 32'd0;
            main_read_q  <= 1'b0;
            main_write_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (legal_req) begin
                        addr_q      <= ADDRESS;
                        wdata_q     <= replicate(req_size, WRITE_DATA);
                        byte_en_q   <= lane_enable(req_size, ADDRESS[1:0]);
                        load_code_q <= MEM_READ;
                        wait_cnt    <= '0;
                        if (req_rd) begin
                            state       <= ST_READ;
                            main_read_q <= 1'b1;
                        end else begin
                            state        <= ST_WRITE;
                            main_write_q <= 1'b1;
                        end
                    end else if (any_req) begin
                        error_q <= 1'b1;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (!MAIN_BUSYWAIT) begin
                        if (state == ST_READ) begin
                            read_data_q <= load_result;
                        end
                        main_read_q  <= 1'b0;
                        main_write_q <= 1'b0;
                        state        <= ST_DONE;
                    end else begin
                        // The wait that reaches the limit abandons the access; READ_DATA keeps its old value.
                        wait_cnt <= wait_next;
                        if (wait_next == CNT_W'(TIMEOUT_CYCLES)) begin
                            main_read_q  <= 1'b0;
                            main_write_q <= 1'b0;
                            error_q      <= 1'b1;
                            state        <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall and strobes are forced low while reset is held, even before the reset edge.
    assign BUSY           = RESET & (((state == ST_IDLE) & legal_req) |
                                     (state == ST_READ) | (state == ST_WRITE));
    assign MAIN_READ      = RESET & main_read_q;
    assign MAIN_WRITE     = RESET & main_write_q;
    assign MAIN_ADDRESS   = addr_q[31:2];
    assign MAIN_WRITEDATA = wdata_q;
    assign MAIN_BYTE_EN   = byte_en_q;
    assign READ_DATA      = read_data_q;
    assign ERROR          = error_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a transaction-level
// model of the load/store rules and a small behavioural memory.
module tb_data_mem_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busy;
    logic        error;
    logic        main_read;
    logic        main_write;
    logic [29:0] main_address;
    logic [31:0] main_writedata;
    logic [3:0]  main_byte_en;
    logic [31:0] main_readdata;
    logic        main_busywait;

    logic [31:0] mem [16];
    logic [31:0] exp_read_data;
    int          vectors = 0;
    int          miscompares = 0;

    data_mem_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK            (clk),
        .RESET          (reset_n),
        .MEM_READ       (mem_read),
        .MEM_WRITE      (mem_write),
        .ADDRESS        (address),
        .WRITE_DATA     (write_data),
        .READ_DATA      (read_data),
        .BUSY           (busy),
        .ERROR          (error),
        .MAIN_READ      (main_read),
        .MAIN_WRITE     (main_write),
        .MAIN_ADDRESS   (main_address),
        .MAIN_WRITEDATA (main_writedata),
        .MAIN_BYTE_EN   (main_byte_en),
        .MAIN_READDATA  (main_readdata),
        .MAIN_BUSYWAIT  (main_busywait)
    );

    always #5 clk = ~clk;

    assign main_readdata = mem[main_address[3:0]];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Width in bytes of a request, 0 when the request is illegal or conflicting.
    function automatic int access_bytes(input logic [2:0] rd, input logic [2:0] wr);
        if (rd != 0 && wr != 0) return 0;
        if (rd != 0) begin
            case (rd)
                3'd1, 3'd4: return 1;
                3'd2, 3'd5: return 2;
                3'd3:       return 4;
                default:    return 0;
            endcase
        end
        case (wr)
            3'd1:    return 1;
            3'd2:    return 2;
            3'd3:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_enable(input int n, input logic [31:0] addr);
        int v;
        v = ((1 << n) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_store_data(input int n, input logic [31:0] wd);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [2:0] rd, input logic [31:0] addr);
        int          n;
        logic [31:0] v;
        n = access_bytes(rd, 3'd0);
        v = word >> (8 * (addr % 4));
        if (n < 4) begin
            v = v & ((32'd1 << (8 * n)) - 32'd1);
            if ((rd == 3'd1 || rd == 3'd2) && v >= (32'd1 << (8 * n - 1)))
                v = v - (32'd1 << (8 * n));
        end
        return v;
    endfunction

    // One complete request: present it for a cycle, play the memory side with
    // 'waits' busy cycles, and check every cycle until the controller is idle again.
    task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int waits);
        int          n;
        bit          legal;
        bit          timeout;
        int          strobes;
        int          busy_seen;
        int          idx;
        logic [3:0]  ben;
        logic [31:0] sdata;

        n     = access_bytes(rd, wr);
        legal = (n != 0) && ((addr % n) == 0);
        idx   = (addr >> 2) % 16;
        ben   = exp_enable(n, addr);
        sdata = exp_store_data(n, wdata);

        mem_read      = rd;
        mem_write     = wr;
        address       = addr;
        write_data    = wdata;
        main_busywait = 1'b0;
        @(negedge clk);
        checkOutput("req_busy", busy, legal);
        checkOutput("req_main_read", main_read, 0);
        checkOutput("req_main_write", main_write, 0);
        checkOutput("req_error", error, 0);
        busy_seen = busy ? 1 : 0;
        @(posedge clk); #1;
        mem_read   = 3'd0;
        mem_write  = 3'd0;
        address    = $urandom;
        write_data = $urandom;

        if (!legal) begin
            @(negedge clk);
            checkOutput("bad_error", error, 1);
            checkOutput("bad_busy", busy, 0);
            checkOutput("bad_main_read", main_read, 0);
            checkOutput("bad_main_write", main_write, 0);
            checkOutput("bad_read_data", read_data, exp_read_data);
            @(posedge clk); #1;
            return;
        end

        timeout = (waits >= TIMEOUT);
        strobes = timeout ? TIMEOUT : waits + 1;
        for (int i = 0; i < strobes; i++) begin
            main_busywait = (i < waits);
            @(negedge clk);
            checkOutput("strobe_read", main_read, rd != 0);
            checkOutput("strobe_write", main_write, wr != 0);
            checkOutput("main_address", main_address, addr >> 2);
            checkOutput("byte_en", main_byte_en, ben);
            if (wr != 0) checkOutput("writedata", main_writedata, sdata);
            checkOutput("strobe_error", error, 0);
            if (busy) busy_seen++;
            @(posedge clk); #1;
        end
        main_busywait = 1'b0;

        @(negedge clk);
        checkOutput("end_main_read", main_read, 0);
        checkOutput("end_main_write", main_write, 0);
        checkOutput("end_busy", busy, 0);
        checkOutput("busy_cycles", busy_seen, 1 + strobes);
        if (timeout) begin
            checkOutput("timeout_error", error, 1);
        end else begin
            checkOutput("done_error", error, 0);
            if (rd != 0) begin
                exp_read_data = exp_load(mem[idx], rd, addr);
            end else begin
                for (int l = 0; l < 4; l++)
                    if (ben[l]) mem[idx][8*l +: 8] = sdata[8*l +: 8];
            end
        end
        checkOutput("read_data", read_data, exp_read_data);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0] rd;
        logic [2:0] wr;
        int         kind;
        int         waits;

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        exp_read_data = 32'd0;

        // Reset with a legal load presented: nothing may stall or strobe.
        reset_n       = 1'b0;
        mem_read      = 3'd3;
        mem_write     = 3'd0;
        address       = 32'd0;
        write_data    = 32'd0;
        main_busywait = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_main_read", main_read, 0);
        checkOutput("rst_main_write", main_write, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_read_data", read_data, 0);
        checkOutput("rst_byte_en", main_byte_en, 0);
        checkOutput("rst_main_address", main_address, 0);
        @(posedge clk); #1;
        reset_n  = 1'b1;
        mem_read = 3'd0;

        $display("[TB] directed cases");
        mem[0] = 32'h80AA_BBCC;
        applyStimulus(3'd1, 3'd0, 32'h0000_0003, 32'd0, 1);
        checkOutput("lb_sign_ext", read_data, 32'hFFFF_FF80);
        applyStimulus(3'd0, 3'd2, 32'h0000_0102, 32'h1234_ABCD, 0);
        applyStimulus(3'd3, 3'd0, 32'h0000_0006, 32'd0, 0);
        applyStimulus(3'd3, 3'd0, 32'h0000_0008, 32'd0, 6);
        applyStimulus(3'd1, 3'd1, 32'h0000_0000, 32'd0, 0);
        applyStimulus(3'd7, 3'd0, 32'h0000_0000, 32'd0, 0);

        // Reset during a stalled store, then a clean LHU.
        mem_write     = 3'd3;
        address       = 32'h0000_0020;
        write_data    = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_write     = 3'd0;
        main_busywait = 1'b1;
        @(negedge clk);
        checkOutput("pre_rst_write", main_write, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_rst_write", main_write, 0);
        checkOutput("mid_rst_error", error, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_read_data", read_data, 0);
        exp_read_data = 32'd0;
        reset_n       = 1'b1;
        main_busywait = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_error", error, 0);
        @(posedge clk); #1;
        mem[4] = 32'h1234_F00D;
        applyStimulus(3'd5, 3'd0, 32'h0000_0010, 32'd0, 0);
        checkOutput("lhu_after_rst", read_data, 32'h0000_F00D);

        $display("[TB] random cases");
        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 9);
            rd   = 3'd0;
            wr   = 3'd0;
            if (kind < 5) begin
                rd = 3'($urandom_range(1, 5));
            end else if (kind < 8) begin
                wr = 3'($urandom_range(1, 3));
            end else if (kind == 8) begin
                rd = 3'($urandom_range(1, 7));
                wr = 3'($urandom_range(1, 7));
            end else if ($urandom_range(0, 1) == 1) begin
                rd = 3'($urandom_range(6, 7));
            end else begin
                wr = 3'($urandom_range(4, 7));
            end
            waits = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
            applyStimulus(rd, wr, 32'($urandom_range(0, 63)), $urandom, waits);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
